id_decode_stage: RTL
====================

Name: id_decode_stage

Overview:
- Instruction-decode pipeline stage of the NPC core, between IF and EX.
- Accepts a fetched 32-bit RV64I instruction plus its PC over a valid/ready handshake.
- Decodes it into a registered bundle: one-hot opcode class, one-hot funct3, register indices, sign-extended immediate and an illegal flag.
- One-hot field decode uses the team's decoder_3_8. The block supplies flow control and flush.

Parameters:
- PC_W, 64, width of PC in/out.
- XLEN, 64, width of the sign-extended immediate.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- flush  input  1  drop held and incoming instruction (branch redirect)
- in_valid  input  1  IF offers instruction
- in_ready  output  1  stage can accept
- in_pc  input  PC_W  PC of offered instruction
- in_inst  input  32  raw instruction
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  EX accepts bundle
- out_pc  output  PC_W  PC of bundle
- out_class  output  13  one-hot class: [0]LUI [1]AUIPC [2]JAL [3]JALR [4]BRANCH [5]LOAD [6]STORE [7]OP_IMM [8]OP [9]OP_IMM_32 [10]OP_32 [11]SYSTEM [12]MISC_MEM
- out_f3_oh  output  8  one-hot of inst[14:12]
- out_f7_alt  output  1  inst[30]
- out_rd  output  5  inst[11:7]
- out_rs1  output  5  inst[19:15]
- out_rs2  output  5  inst[24:20]
- out_imm  output  XLEN  sign-extended immediate
- out_illegal  output  1  unrecognised encoding

Behaviour:
- Reset: all outputs registered and cleared to 0 (out_valid=0, out_class=0, out_imm=0, etc.); in_ready=1 on the first cycle after reset.
- Latency: one cycle. An instruction accepted at edge N appears on outputs after edge N.
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Handshake: outputs are held stable while out_valid && !out_ready.
- Base in_ready (feature off): in_ready = !out_valid || out_ready, combinational. Simultaneous output transfer and input accept replaces the bundle in the same edge, so there is no bubble.
- in_valid may drop without a transfer. in_inst/in_pc are sampled only on a transfer.
- Flush:
  - Next edge: out_valid=0, any skid entry discarded.
  - An instruction offered in the flush cycle is not accepted; in_ready is forced 0 while flush=1.
  - Flush and rst together behave as rst.
- Class decode on inst[6:2]:
  - 01101 LUI, 00101 AUIPC, 11011 JAL, 11001 JALR, 11000 BRANCH
  - 00000 LOAD, 01000 STORE, 00100 OP_IMM, 01100 OP, 00110 OP_IMM_32
  - 01110 OP_32, 11100 SYSTEM, 00011 MISC_MEM
- Illegal: out_illegal=1 and out_class=0 when inst[1:0]!=2'b11 or the opcode is unlisted. Field outputs are still driven from the raw bits.
- Immediate, sign bit inst[31] extended to XLEN:
  - I: inst[31:20] (JALR, LOAD, OP_IMM, OP_IMM_32, SYSTEM, MISC_MEM)
  - S: {inst[31:25],inst[11:7]}
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}
  - U: {inst[31:12],12'b0}, sign-extended from bit 31
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}
  - OP, OP_32, illegal: 0
- out_f3_oh from decoder_3_8(inst[14:12]); always exactly one bit set when out_valid.
- Reset mid-stall: bundle discarded, out_valid=0 next cycle.

Optional Feature:
- Macro: ID_SKID_BUF_EN.
- Defined:
  - in_ready = !skid_valid, driven from a flop, so no combinational path from out_ready to in_ready.
  - If input is accepted while the output is stalled, the new instruction is decoded into a one-entry skid register.
  - When EX accepts the bundle, the skid contents move to the output.
  - Ordering is strictly FIFO. Capacity is output plus skid = 2.
  - Flush clears both.
- Undefined: no skid register; in_ready follows the combinational rule above.

Test Plan:
- Reset, then in_inst=0x00510093 (addi x1,x2,5), in_pc=0x80000000, out_ready=1 -> next cycle out_valid=1, out_class=13'h0080, out_rd=1, out_rs1=2, out_imm=5, out_f3_oh=8'h01, out_pc=0x80000000.
- in_inst=0x123452B7 (lui x5,0x12345) -> out_class=13'h0001, out_rd=5, out_imm=0x0000000012345000. In_inst=0xFFDFF06F (jal x0,-4) -> out_class=13'h0004, out_imm=0xFFFFFFFFFFFFFFFC.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 and a stream of addi x1..x4 -> bundle unchanged.
  - Feature off: in_ready=0 during the stall.
  - Feature on: one extra accepted, then in_ready=0.
  - After release: outputs x1,x2,x3 in order, none lost or duplicated.
- in_inst=0x00000000 -> out_illegal=1, out_class=0, out_imm=0. In_inst=0x0000007F -> out_illegal=1.
- Stalled valid bundle plus flush=1 with in_valid=1 -> next cycle out_valid=0, offered instruction not accepted, in_ready=0 during flush. Then back-to-back flow resumes at one instruction per cycle.
- rst asserted during a stall -> out_valid=0 and all outputs 0 the following cycle.

Source files
------------

// File: rtl/id_decode_stage.sv
// RV64I instruction-decode stage (IF -> EX) with valid/ready flow control and flush.
// Optional macro ID_SKID_BUF_EN adds a one-entry skid register so in_ready comes from a flop.
module decoder_3_8 (
  input  logic [2:0] sel,
  output logic [7:0] oh
);
  for (genvar gi = 0; gi < 8; gi++) begin : g_oh
    assign oh[gi] = (sel == 3'(gi));
  end
endmodule

module id_decode_stage #(
  parameter int PC_W = 64,
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [12:0]     out_class,
  output logic [7:0]      out_f3_oh,
  output logic            out_f7_alt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);
  localparam int C_LUI       = 0;
  localparam int C_AUIPC     = 1;
  localparam int C_JAL       = 2;
  localparam int C_JALR      = 3;
  localparam int C_BRANCH    = 4;
  localparam int C_LOAD      = 5;
  localparam int C_STORE     = 6;
  localparam int C_OP_IMM    = 7;
  localparam int C_OP        = 8;
  localparam int C_OP_IMM_32 = 9;
  localparam int C_OP_32     = 10;
  localparam int C_SYSTEM    = 11;
  localparam int C_MISC_MEM  = 12;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [12:0]     cls;
    logic [7:0]      f3_oh;
    logic            f7_alt;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } bundle_t;

  logic [12:0]     cls_next;
  logic [7:0]      f3_oh_next;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0]     imm32_next;
  bundle_t         dec_next;
  bundle_t         out_reg;
  logic            out_valid_reg;
  logic            in_fire;

  decoder_3_8 u_f3_dec (
    .sel (in_inst[14:12]),
    .oh  (f3_oh_next)
  );

  // Non-32-bit encodings (inst[1:0] != 11) never match a class.
  always_comb begin
    cls_next = '0;
    if (in_inst[1:0] == 2'b11) begin
      case (in_inst[6:2])
        5'b01101: cls_next[C_LUI]       = 1'b1;
        5'b00101: cls_next[C_AUIPC]     = 1'b1;
        5'b11011: cls_next[C_JAL]       = 1'b1;
        5'b11001: cls_next[C_JALR]      = 1'b1;
        5'b11000: cls_next[C_BRANCH]    = 1'b1;
        5'b00000: cls_next[C_LOAD]      = 1'b1;
        5'b01000: cls_next[C_STORE]     = 1'b1;
        5'b00100: cls_next[C_OP_IMM]    = 1'b1;
        5'b01100: cls_next[C_OP]        = 1'b1;
        5'b00110: cls_next[C_OP_IMM_32] = 1'b1;
        5'b01110: cls_next[C_OP_32]     = 1'b1;
        5'b11100: cls_next[C_SYSTEM]    = 1'b1;
        5'b00011: cls_next[C_MISC_MEM]  = 1'b1;
        default:  cls_next              = '0;
      endcase
    end
  end

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                  in_inst[11:8], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                  in_inst[30:21], 1'b0};

  always_comb begin
    imm32_next = '0;
    if (cls_next[C_JALR] | cls_next[C_LOAD] | cls_next[C_OP_IMM] |
        cls_next[C_OP_IMM_32] | cls_next[C_SYSTEM] | cls_next[C_MISC_MEM])
      imm32_next = imm_i;
    else if (cls_next[C_STORE])
      imm32_next = imm_s;
    else if (cls_next[C_BRANCH])
      imm32_next = imm_b;
    else if (cls_next[C_LUI] | cls_next[C_AUIPC])
      imm32_next = imm_u;
    else if (cls_next[C_JAL])
      imm32_next = imm_j;
  end

  always_comb begin
    dec_next         = '0;
    dec_next.pc      = in_pc;
    dec_next.cls     = cls_next;
    dec_next.f3_oh   = f3_oh_next;
    dec_next.f7_alt  = in_inst[30];
    dec_next.rd      = in_inst[11:7];
    dec_next.rs1     = in_inst[19:15];
    dec_next.rs2     = in_inst[24:20];
    dec_next.imm     = XLEN'($signed(imm32_next));
    dec_next.illegal = ~|cls_next;
  end

  assign in_fire = in_valid & in_ready;

`ifdef ID_SKID_BUF_EN
  bundle_t skid_reg;
  logic    skid_valid_reg;

  // Registered ready: only the flush override reaches in_ready combinationally.
  assign in_ready = ~skid_valid_reg & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_reg        <= '0;
      skid_valid_reg <= 1'b0;
      skid_reg       <= '0;
    end else if (flush) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!out_valid_reg || out_ready) begin
      if (skid_valid_reg) begin
        out_reg        <= skid_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (in_fire) begin
        out_reg       <= dec_next;
        out_valid_reg <= 1'b1;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end else if (in_fire) begin
      skid_reg       <= dec_next;
      skid_valid_reg <= 1'b1;
    end
  end
`else
  assign in_ready = ~flush & (~out_valid_reg | out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_reg       <= '0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (in_fire) begin
      out_reg       <= dec_next;
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end
`endif

  assign out_valid   = out_valid_reg;
  assign out_pc      = out_reg.pc;
  assign out_class   = out_reg.cls;
  assign out_f3_oh   = out_reg.f3_oh;
  assign out_f7_alt  = out_reg.f7_alt;
  assign out_rd      = out_reg.rd;
  assign out_rs1     = out_reg.rs1;
  assign out_rs2     = out_reg.rs2;
  assign out_imm     = out_reg.imm;
  assign out_illegal = out_reg.illegal;
endmodule
